regfile_2r1w: RTL

- 32-entry × 32-bit MIPS-style register file; the direct consumer of the single-bit/32-bit enabled D flip-flop storage cells.
- Adds around the storage words:
  - a 5-to-32 write-enable decoder
  - two combinational read-port multiplexers
  - a hardwired-zero register 0
  - optional same-cycle write-to-read bypass
- Sits between instruction decode (register addresses) and the ALU operand path (read data), with write-back driving the write port.

---
 rtl/regfile_2r1w_if.sv | 21 ++
 rtl/regfile_2r1w.sv | 27 ++
 2 files changed

// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: address/data bundle between decode/write-back (master) and the register file (slave)
interface regfile_2r1w_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [ADDR_W-1:0] WriteRegister;
   logic [WIDTH-1:0]  WriteData;
   logic              RegWrite;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;
   modport master (
      output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      input  ReadData1, ReadData2
   );
   modport slave (
      input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file, r0 hardwired to zero, optional write-to-read bypass
module regfile_2r1w #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input logic             clk,
   input logic             reset,
   regfile_2r1w_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] we;
   logic             hit1, hit2;
   // word 0 is never enabled, so after reset it stays at zero
   always_comb we = (bus.RegWrite && bus.WriteRegister != '0) ? DEPTH'(1) << bus.WriteRegister : '0;
   always_ff @(posedge clk)
      for (int i = 0; i < DEPTH; i++)
         if (reset) mem[i] <= '0;
         else if (we[i]) mem[i] <= bus.WriteData;
   always_comb begin
      hit1 = BYPASS != 0 && !reset && we != '0 && bus.ReadRegister1 == bus.WriteRegister;
      hit2 = BYPASS != 0 && !reset && we != '0 && bus.ReadRegister2 == bus.WriteRegister;
      bus.ReadData1 = bus.ReadRegister1 == '0 ? '0 : hit1 ? bus.WriteData : mem[bus.ReadRegister1];
      bus.ReadData2 = bus.ReadRegister2 == '0 ? '0 : hit2 ? bus.WriteData : mem[bus.ReadRegister2];
   end
endmodule
